fifo_write_arbiter: RTL and testbench
=====================================

# fifo_write_arbiter

Round-robin arbiter that shares the single write port of the CDC FIFO (`fifo`, FIFO_WIDTH/FIFO_DEPTH parameterised) between NUM_REQ independent producers. Each producer presents a valid/ready/data channel; the arbiter grants one per cycle, registers the winning word into an output stage, and drives the FIFO's writeValid/writeData until writeReady accepts it. Sits directly in front of the FIFO write side, same clock domain as the writer.

## Interface
- NUM_REQ, 4, number of requesters (2..16)
- FIFO_WIDTH, 8, data word width; must match the downstream FIFO
- ID_W, $clog2(NUM_REQ), width of grant index (derived, not overridden)
- clk  in  1  write-side clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- reqValid  in  NUM_REQ  per-requester word available
- reqData  in  NUM_REQ*FIFO_WIDTH  flattened words; requester i at bits [i*FIFO_WIDTH +: FIFO_WIDTH]
- reqReady  out  NUM_REQ  one-hot (or zero) accept strobe; word i consumed on edge where reqValid[i] && reqReady[i]
- writeValid  out  1  output stage holds a word for the FIFO
- writeData  out  FIFO_WIDTH  word offered to the FIFO
- writeReady  in  1  FIFO accepts; transfer on edge where writeValid && writeReady
- grantId  out  ID_W  index of requester whose word is in the output stage
- grantCount  out  NUM_REQ*16  per-requester accepted-word counters (only with FIFO_ARB_STATS_EN)

## Operation
- States: IDLE (output stage empty, writeValid=0), OFFER (output stage full, writeValid=1).
- Load condition `load` = (state==IDLE) || (writeValid && writeReady).
- Arbitration (combinational): search reqValid starting at index `ptr`, ascending, wrapping at NUM_REQ-1 → 0; first set bit wins. `ptr` is the register holding the next-priority index.
- reqReady[w] = load && reqValid[w] for winner w only; all other bits 0. reqReady is combinational, depends on writeReady in the same cycle.
- On edge with load && any reqValid: writeData ← reqData[w], grantId ← w, ptr ← (w+1) mod NUM_REQ, state → OFFER.
- On edge with load && no reqValid: state → IDLE; writeData/grantId hold last values; ptr unchanged.
- OFFER && !writeReady: all outputs held stable, reqReady = 0 (no new grant while stalled).
- Simultaneous FIFO accept and new request: accept and reload on the same edge; writeValid stays 1 (back-to-back, no bubble).
- ptr wrap: when w = NUM_REQ-1, ptr ← 0.
- Requesters must hold reqValid/reqData stable until accepted; arbiter does not check.

## Timing
- Reset values: writeValid=0, writeData=0, grantId=0, reqReady=0 (state IDLE, no load from reset cycle), ptr=0, grantCount=0.
- rst asserted mid-OFFER: on that edge, pending word discarded, state → IDLE, ptr → 0; no reqReady during any rst-high cycle.
- Latency: reqValid high in cycle t (arbiter IDLE) → reqReady in t, writeValid high from t+1.
- Throughput: one word per cycle when writeReady is held high and requests are present.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,NUM_REQ-1,0,…; any continuously-valid requester is served within NUM_REQ accepted words.

## Configuration
- FIFO_ARB_STATS_EN defined: grantCount port present; counter i increments by 1 on each edge where reqValid[i] && reqReady[i]; 16-bit, wraps 0xFFFF → 0x0000; cleared by rst.
- Not defined: grantCount port and counters absent; no other behaviour change.

## Structure
- Package fifo_arb_pkg: state enum (IDLE, OFFER), stats counter width constant CNT_W=16, max NUM_REQ constant.
- One sub-module: rr_pick (NUM_REQ-wide request vector + start pointer → winner index + found flag), purely combinational, instantiated once.

## Test plan
- Reset: hold rst 3 cycles with all reqValid=1 → writeValid=0, reqReady=0 throughout; first grant after release goes to requester 0.
- Rotation: NUM_REQ=4, all reqValid=1, writeReady=1, reqData[i]=0x10+i → writeData sequence 0x10,0x11,0x12,0x13,0x10, one per cycle, no bubbles.
- Stall: word 0xA5 from requester 2 in OFFER, writeReady=0 for 5 cycles → writeData=0xA5, grantId=2 stable, reqReady=0 for all 5 cycles; accepted on first writeReady=1.
- Sparse/wrap: only requesters 3 and 1 valid, ptr at 2 → grant order 3,1,3,1; ptr after grant 3 is 0.
- Mid-operation reset: rst pulsed while OFFER holds 0x5A → next cycle writeValid=0, 0x5A never accepted, ptr=0.
- Stats (FIFO_ARB_STATS_EN): 65537 accepted words from requester 0 → grantCount[15:0]=0x0001, other counters 0.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// ---------------------------------------------------------------------------
// fifo_arb_pkg
//   Shared definitions for the FIFO write-port arbiter.
//   - arb_state_e : output-stage state (IDLE = empty, OFFER = word held)
//   - CNT_W       : width of each per-requester accepted-word counter
//   - MAX_NUM_REQ : largest supported number of requesters
// ---------------------------------------------------------------------------
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } arb_state_e;

    localparam int CNT_W       = 16;
    localparam int MAX_NUM_REQ = 16;

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Purely combinational round-robin search. Scans req upward starting at
//   index start, wrapping from N-1 back to 0; the first set bit wins.
//   Ports:
//     req    in  N  request vector
//     start  in  W  index with highest priority this cycle
//     winner out W  index of the winning request (0 when none)
//     found  out 1  at least one request bit is set
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter  int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic [W-1:0] winner,
    output logic         found
);

    always_comb begin
        int idx;
        idx    = 0;
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < N; k++) begin
            // start + k never exceeds 2N-2, so one subtraction wraps it.
            idx = int'(start) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[W'(idx)]) begin
                found  = 1'b1;
                winner = W'(idx);
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_write_arbiter
//   Round-robin arbiter sharing one FIFO write port between NUM_REQ
//   producers. One requester is granted per cycle; its word is registered
//   into a single output stage that is offered to the FIFO until accepted.
//
//   Handshakes (both sides): a word moves on the rising edge where valid and
//   ready are both high. valid/data must be held stable until that edge;
//   ready may depend combinationally on the other side's ready.
//
//   Ports:
//     clk         in   1                   write-side clock
//     rst         in   1                   synchronous active-high reset
//     reqValid    in   NUM_REQ             per-requester word available
//     reqData     in   NUM_REQ*FIFO_WIDTH  requester i at [i*FIFO_WIDTH +: FIFO_WIDTH]
//     reqReady    out  NUM_REQ             one-hot accept strobe (combinational)
//     writeValid  out  1                   output stage holds a word
//     writeData   out  FIFO_WIDTH          word offered to the FIFO
//     writeReady  in   1                   FIFO accepts the offered word
//     grantId     out  ID_W                requester owning the held word
//     state_dbg   out  1                   current output-stage state
//     grantCount  out  NUM_REQ*16          per-requester accepted-word counters
//                                          (present only with FIFO_ARB_STATS_EN)
//
//   Build option: define FIFO_ARB_STATS_EN to add the grantCount counters.
// ---------------------------------------------------------------------------
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int FIFO_WIDTH = 8,
    localparam int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            reqValid,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] reqData,
    output logic [NUM_REQ-1:0]            reqReady,
    output logic                          writeValid,
    output logic [FIFO_WIDTH-1:0]         writeData,
    input  logic                          writeReady,
    output logic [ID_W-1:0]               grantId,
    output logic                          state_dbg
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [NUM_REQ*CNT_W-1:0]      grantCount
`endif
);

    localparam logic [0:0] ST_IDLE  = IDLE;
    localparam logic [0:0] ST_OFFER = OFFER;

    logic [0:0]            state;
    logic [ID_W-1:0]       ptr;
    logic [ID_W-1:0]       win;
    logic                  found;
    logic                  load;
    logic [FIFO_WIDTH-1:0] win_data;

    rr_pick #(
        .N(NUM_REQ)
    ) u_rr_pick (
        .req    (reqValid),
        .start  (ptr),
        .winner (win),
        .found  (found)
    );

    assign writeValid = (state == ST_OFFER);
    assign state_dbg  = state;

    // The stage can take a new word when empty, or when the held word
    // leaves on this same edge (back-to-back, no bubble).
    assign load = (state == ST_IDLE) || (writeValid && writeReady);

    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win == ID_W'(i)) begin
                win_data = reqData[i*FIFO_WIDTH +: FIFO_WIDTH];
            end
        end
    end

    // Grant strobe is suppressed while rst is high so no word is consumed
    // by an edge that also wipes the output stage.
    always_comb begin
        reqReady = '0;
        if (load && found && !rst) begin
            reqReady[win] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            writeData <= '0;
            grantId   <= '0;
            ptr       <= '0;
        end else if (load) begin
            if (found) begin
                state     <= ST_OFFER;
                writeData <= win_data;
                grantId   <= win;
                ptr       <= (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
            end else begin
                state <= ST_IDLE;
            end
        end
    end

`ifdef FIFO_ARB_STATS_EN
    // Counters wrap naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            grantCount <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (reqValid[i] && reqReady[i]) begin
                    grantCount[i*CNT_W +: CNT_W] <= grantCount[i*CNT_W +: CNT_W] + 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_write_arbiter
//   Directed bench for fifo_write_arbiter with NUM_REQ=4, FIFO_WIDTH=8.
//   Inputs change 1 time unit after the rising edge; outputs are sampled on
//   the falling edge. A table of per-cycle vectors covers rotation, sparse
//   requests with wrap, stall and drain; hand-written sequences cover the
//   long stall, mid-operation reset and (with FIFO_ARB_STATS_EN) counters.
//   A queue of expected FIFO writes is checked on every accepted transfer.
// ---------------------------------------------------------------------------
module tb_fifo_write_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int FIFO_WIDTH = 8;

    logic                          clk;
    logic                          rst;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          write_valid;
    logic [FIFO_WIDTH-1:0]         write_data;
    logic                          write_ready;
    logic [1:0]                    grant_id;
    logic                          state_dbg;
`ifdef FIFO_ARB_STATS_EN
    logic [NUM_REQ*16-1:0]         grant_count;
`endif

    int checks;
    int errors;
    bit mon_en;
    logic [FIFO_WIDTH-1:0] exp_q[$];

    fifo_write_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .FIFO_WIDTH (FIFO_WIDTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .reqValid   (req_valid),
        .reqData    (req_data),
        .reqReady   (req_ready),
        .writeValid (write_valid),
        .writeData  (write_data),
        .writeReady (write_ready),
        .grantId    (grant_id),
        .state_dbg  (state_dbg)
`ifdef FIFO_ARB_STATS_EN
        ,
        .grantCount (grant_count)
`endif
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [NUM_REQ-1:0] v, input logic wr);
        req_valid   = v;
        write_ready = wr;
    endtask

    task automatic check_outputs(input string tag, input logic [3:0] rr, input logic wv,
                                 input logic [7:0] wd, input logic [1:0] g);
        check({tag, ".reqReady"},   32'(req_ready),   32'(rr));
        check({tag, ".writeValid"}, 32'(write_valid), 32'(wv));
        check({tag, ".state_dbg"},  32'(state_dbg),   32'(wv));
        check({tag, ".writeData"},  32'(write_data),  32'(wd));
        check({tag, ".grantId"},    32'(grant_id),    32'(g));
    endtask

    // ---------------- scoreboard of FIFO writes ----------------
    always @(negedge clk) begin
        if (mon_en && !rst && write_valid && write_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL fifo_write unexpected word actual=%0h expected=none", write_data);
            end else begin
                logic [FIFO_WIDTH-1:0] e;
                e = exp_q.pop_front();
                if (write_data !== e) begin
                    errors++;
                    $display("FAIL fifo_write actual=%0h expected=%0h", write_data, e);
                end
            end
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0] valid;
        logic       wr;
        logic [3:0] exp_rr;
        logic       exp_wv;
        logic [7:0] exp_wd;
        logic [1:0] exp_g;
    } vec_t;

    vec_t vecs[16];

    initial begin
        checks      = 0;
        errors      = 0;
        mon_en      = 1'b1;
        rst         = 1'b1;
        req_valid   = '0;
        write_ready = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_data[i*FIFO_WIDTH +: FIFO_WIDTH] = 8'(8'h10 + i);
        end

        // Words the FIFO must receive, in order, across the whole run.
        exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10,
                  8'h11, 8'h13, 8'h11, 8'h13, 8'h11,
                  8'hA5};

        //          valid  wr    reqReady wv    wData  grant
        vecs[0]  = '{4'hF, 1'b1, 4'h1, 1'b0, 8'h00, 2'd0}; // first grant to 0
        vecs[1]  = '{4'hF, 1'b1, 4'h2, 1'b1, 8'h10, 2'd0};
        vecs[2]  = '{4'hF, 1'b1, 4'h4, 1'b1, 8'h11, 2'd1};
        vecs[3]  = '{4'hF, 1'b1, 4'h8, 1'b1, 8'h12, 2'd2};
        vecs[4]  = '{4'hF, 1'b1, 4'h1, 1'b1, 8'h13, 2'd3}; // wrap to 0
        vecs[5]  = '{4'h0, 1'b1, 4'h0, 1'b1, 8'h10, 2'd0}; // drain
        vecs[6]  = '{4'h0, 1'b0, 4'h0, 1'b0, 8'h10, 2'd0}; // idle holds data
        vecs[7]  = '{4'h2, 1'b1, 4'h2, 1'b0, 8'h10, 2'd0}; // ptr 1 -> grant 1
        vecs[8]  = '{4'hA, 1'b1, 4'h8, 1'b1, 8'h11, 2'd1}; // ptr 2 -> 3
        vecs[9]  = '{4'hA, 1'b1, 4'h2, 1'b1, 8'h13, 2'd3}; // ptr 0 -> 1
        vecs[10] = '{4'hA, 1'b1, 4'h8, 1'b1, 8'h11, 2'd1};
        vecs[11] = '{4'hA, 1'b1, 4'h2, 1'b1, 8'h13, 2'd3};
        vecs[12] = '{4'hA, 1'b0, 4'h0, 1'b1, 8'h11, 2'd1}; // stall
        vecs[13] = '{4'hA, 1'b0, 4'h0, 1'b1, 8'h11, 2'd1};
        vecs[14] = '{4'h0, 1'b1, 4'h0, 1'b1, 8'h11, 2'd1}; // accept, empty
        vecs[15] = '{4'h0, 1'b0, 4'h0, 1'b0, 8'h11, 2'd1};

        // ---------------- reset with all requesters valid ----------------
        next_cycle();
        drive(4'hF, 1'b1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("reset[%0d].writeValid", c), 32'(write_valid), 32'd0);
            check($sformatf("reset[%0d].reqReady", c),   32'(req_ready),   32'd0);
            next_cycle();
        end
        check("reset.writeData", 32'(write_data), 32'h0);
        check("reset.grantId",   32'(grant_id),   32'h0);
        rst = 1'b0;

        // ---------------- table-driven section ----------------
        for (int v = 0; v < 16; v++) begin
            drive(vecs[v].valid, vecs[v].wr);
            @(negedge clk);
            check_outputs($sformatf("vec%0d", v), vecs[v].exp_rr, vecs[v].exp_wv,
                          vecs[v].exp_wd, vecs[v].exp_g);
            next_cycle();
        end

        // ---------------- long stall: 0xA5 from requester 2 (ptr = 2) ----
        req_data[2*FIFO_WIDTH +: FIFO_WIDTH] = 8'hA5;
        drive(4'h4, 1'b0);
        @(negedge clk);
        check("stall.grant.reqReady", 32'(req_ready), 32'h4);
        next_cycle();
        drive(4'hF, 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_outputs($sformatf("stall%0d", c), 4'h0, 1'b1, 8'hA5, 2'd2);
            next_cycle();
        end
        drive(4'h0, 1'b1);
        @(negedge clk);
        check_outputs("stall.accept", 4'h0, 1'b1, 8'hA5, 2'd2);
        next_cycle();
        drive(4'h0, 1'b0);
        @(negedge clk);
        check("stall.after.writeValid", 32'(write_valid), 32'd0);
        next_cycle();

        // ---------------- mid-operation reset (ptr = 3) ----------------
        req_data[1*FIFO_WIDTH +: FIFO_WIDTH] = 8'h5A;
        drive(4'h2, 1'b0);
        @(negedge clk);
        check("midrst.grant.reqReady", 32'(req_ready), 32'h2);
        next_cycle();
        drive(4'h0, 1'b0);
        @(negedge clk);
        check_outputs("midrst.offer", 4'h0, 1'b1, 8'h5A, 2'd1);
        next_cycle();
        rst = 1'b1;
        drive(4'hF, 1'b0);
        @(negedge clk);
        check("midrst.rst.reqReady", 32'(req_ready), 32'h0);
        next_cycle();
        rst = 1'b0;
        drive(4'hF, 1'b1);
        // ptr back at 0 -> requester 0 wins even though the last grant was 1.
        @(negedge clk);
        check_outputs("midrst.after", 4'h1, 1'b0, 8'h00, 2'd0);
        next_cycle();
        drive(4'h0, 1'b0);
        @(negedge clk);
        check_outputs("midrst.reload", 4'h0, 1'b1, 8'h10, 2'd0);
        next_cycle();

        check("scoreboard.drained", 32'(exp_q.size()), 32'd0);

`ifdef FIFO_ARB_STATS_EN
        // ---------------- counter wrap: 65537 words from requester 0 ----
        mon_en = 1'b0;
        rst    = 1'b1;
        next_cycle();
        rst = 1'b0;
        drive(4'h1, 1'b1);
        for (int c = 0; c < 65537; c++) begin
            next_cycle();
        end
        drive(4'h0, 1'b0);
        @(negedge clk);
        check("stats.cnt0", 32'(grant_count[0*16 +: 16]), 32'h0001);
        check("stats.cnt1", 32'(grant_count[1*16 +: 16]), 32'h0000);
        check("stats.cnt2", 32'(grant_count[2*16 +: 16]), 32'h0000);
        check("stats.cnt3", 32'(grant_count[3*16 +: 16]), 32'h0000);
        next_cycle();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
